// File: rtl/ysyx_220053_ifq.sv
// Instruction fetch queue between IFU and IDU: DEPTH-entry {pc, instr} FIFO with flush.
// Optional zero-latency empty-queue bypass when IFQ_BYPASS_EN is defined.
module ysyx_220053_ifq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PC_W-1:0]  pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];

  logic [AW-1:0] widx_c;
  logic [AW-1:0] ridx_c;
  logic          empty_c;
  logic          full_c;
  logic          bypass_c;
  logic          push_c;
  logic          pop_c;

  // Status, handshake and head selection; flush masks out_valid and push in the same cycle.
  always_comb begin
    widx_c  = wptr_q[AW-1:0];
    ridx_c  = rptr_q[AW-1:0];
    empty_c = (wptr_q == rptr_q);
    full_c  = (widx_c == ridx_c) && (wptr_q[AW] != rptr_q[AW]);
`ifdef IFQ_BYPASS_EN
    bypass_c = empty_c & in_valid & ~flush & ~rst;
`else
    bypass_c = 1'b0;
`endif
    in_ready  = ~rst & ~full_c;
    out_valid = ~rst & ~flush & (~empty_c | bypass_c);
    pop_c     = out_valid & out_ready & ~empty_c;
    // A bypassed entry taken by IDU in the same cycle is never stored.
    push_c    = in_valid & in_ready & ~flush & ~(bypass_c & out_ready);
    wptr_d    = wptr_q + PTR_W'(push_c);
    rptr_d    = rptr_q + PTR_W'(pop_c);

    out_pc    = '0;
    out_instr = '0;
    if (!rst) begin
      if (!empty_c) begin
        out_pc    = pc_mem_q[ridx_c];
        out_instr = instr_mem_q[ridx_c];
      end else if (bypass_c) begin
        out_pc    = in_pc;
        out_instr = in_instr;
      end
    end
    count = rst ? '0 : (wptr_q - rptr_q);
  end

  // Pointer state; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      pc_mem_q[widx_c]    <= in_pc;
      instr_mem_q[widx_c] <= in_instr;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_ifq.sv
// Self-checking bench for ysyx_220053_ifq: queue-based reference model plus directed literal checks.
// Define IFQ_BYPASS_EN for both bench and RTL to exercise the bypass build.
module tb_ysyx_220053_ifq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 64;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc = '0;
  logic [31:0]      in_instr = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  out_pc;
  logic [31:0]      out_instr;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_err = 0;
  int dut_pops = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t q[$];

  ysyx_220053_ifq #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from the queue contents and the current inputs.
  function automatic logic m_in_ready();
    return !rst && (q.size() < int'(DEPTH));
  endfunction

  function automatic logic m_out_valid();
    return !rst && !flush && (q.size() > 0 || (BYP && in_valid));
  endfunction

  function automatic ent_t m_head();
    ent_t e;
    e = '0;
    if (!rst) begin
      if (q.size() > 0) e = q[0];
      else if (BYP && in_valid && !flush) begin
        e.pc  = in_pc;
        e.ins = in_instr;
      end
    end
    return e;
  endfunction

  function automatic logic [63:0] m_count();
    return rst ? 64'd0 : 64'(q.size());
  endfunction

  // Reference model update at each rising edge.
  always @(posedge clk) begin : model
    logic v, acc, pop;
    v   = m_out_valid();
    acc = in_valid && m_in_ready();
    pop = v && out_ready;
    if (rst || flush) begin
      q.delete();
    end else if (pop && q.size() == 0) begin
      // bypassed straight through; nothing stored
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{pc: 64'(in_pc), ins: in_instr});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    ent_t h;
    h = m_head();
    chk("in_ready",  64'(in_ready),  64'(m_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_out_valid()));
    chk("count",     64'(count),     m_count());
    chk("out_pc",    64'(out_pc),    h.pc);
    chk("out_instr", 64'(out_instr), 64'(h.ins));
    if (out_valid && out_ready) dut_pops++;
  end

  task automatic drive(input logic r, input logic v, input logic [63:0] pc,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_pc     = PC_W'(pc);
    in_instr  = $urandom;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    // Reset held two cycles with in_valid high.
    drive(1, 1, 64'h8000_0000, 0, 0);
    drive(1, 1, 64'h8000_0000, 0, 0);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    drive(0, 0, 64'h0, 0, 0);
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_count",    64'(count),    64'd0);

    // Fill with IDU stalled, attempt a 5th push, then drain.
    for (int i = 0; i < 4; i++) drive(0, 1, 64'h8000_0000 + 64'(4 * i), 0, 0);
    drive(0, 1, 64'h8000_0010, 0, 0);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count",    64'(count),    64'd4);
    drive(0, 0, 64'h0, 1, 0);
    @(negedge clk);
    chk("drain_first_pc", 64'(out_pc), 64'h8000_0000);
    for (int i = 0; i < 5; i++) drive(0, 0, 64'h0, 1, 0);
    @(negedge clk);
    chk("drained_count", 64'(count), 64'd0);

    // Streaming with both sides always ready.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 64'h8000_0000 + 64'(4 * i), 1, 0);
      @(negedge clk);
      chk("stream_cnt_le1", 64'(count <= 1), 64'd1);
      if (i == 0) chk("stream_first_valid", 64'(out_valid), BYP ? 64'd1 : 64'd0);
      if (i == 1) begin
        chk("stream_second_valid", 64'(out_valid), 64'd1);
        chk("stream_second_pc", 64'(out_pc), BYP ? 64'h8000_0004 : 64'h8000_0000);
      end
    end
    drive(0, 0, 64'h0, 1, 0);
    drive(0, 0, 64'h0, 1, 0);

    // Flush with 3 entries held and an incoming entry that must be dropped.
    for (int i = 0; i < 3; i++) drive(0, 1, 64'h8000_0020 + 64'(4 * i), 0, 0);
    drive(0, 1, 64'h8000_0100, 1, 1);
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 64'h0, 1, 0);
    @(negedge clk);
    chk("post_flush_count", 64'(count),     64'd0);
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 64'h0, 1, 0);

`ifdef IFQ_BYPASS_EN
    // Zero-latency bypass on an empty queue.
    drive(0, 1, 64'h8000_0010, 1, 0);
    @(negedge clk);
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_pc",    64'(out_pc),    64'h8000_0010);
    chk("byp_count", 64'(count),     64'd0);
    drive(0, 0, 64'h0, 1, 0);
    @(negedge clk);
    chk("byp_after_count", 64'(count), 64'd0);
`endif

    // Randomized traffic with occasional flush; the compare process tracks the model.
    for (int i = 0; i < 1000; i++) begin
      drive(0, ($urandom % 4) != 0, 64'h9000_0000 + 64'(4 * i),
            ($urandom % 2) != 0, ($urandom % 64) == 0);
    end
    for (int i = 0; i < 8; i++) drive(0, 0, 64'h0, 1, 0);
    @(negedge clk);
    chk("final_count", 64'(count), 64'd0);
    chk("enough_pops_for_wraps", 64'(dut_pops >= 20 * int'(DEPTH)), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
